bcd_to_bin_seq: RTL and testbench

//  Sequential multi-digit BCD-to-binary decoder; the inverse path of the BCD adder.

---
 rtl/bcd_to_bin_seq.sv | 117 +++++++++++
 tb/tb_bcd_to_bin_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter. Each clock takes one digit, most significant first,
// and folds it into the running value with acc*10 + digit. It also flags any nibble above 9.
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int ACC_W = BIN_W + 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [4*DIGITS-1:0]  shadow_q, shadow_d;
    logic [BIN_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 errAcc_q, errAcc_d;
    logic [BIN_W-1:0]     binOut_q, binOut_d;
    logic                 err_q, err_d;

    logic [3:0]           digit;
    logic [BIN_W-1:0]     accNext;
    logic                 errNext;

    // The shadow word shifts left once per digit, so the current digit is always the top nibble.
    assign digit   = shadow_q[4*DIGITS-1 -: 4];
    assign accNext = BIN_W'(({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1)
                            + ACC_W'(digit));
    assign errNext = errAcc_q | (digit > 4'd9);

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        errAcc_d = errAcc_q;
        binOut_d = binOut_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CONV;
                    shadow_d = bcd_in;
                    acc_d    = '0;
                    cnt_d    = '0;
                    errAcc_d = 1'b0;
                end
            end
            CONV: begin
                shadow_d = shadow_q << 4;
                acc_d    = accNext;
                errAcc_d = errNext;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    binOut_d = errNext ? '0 : accNext;
                    err_d    = errNext;
                end
            end
            DONE: begin
                // A start request in this state begins a new conversion immediately.
                if (start) begin
                    state_d  = CONV;
                    shadow_d = bcd_in;
                    acc_d    = '0;
                    cnt_d    = '0;
                    errAcc_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            errAcc_q <= 1'b0;
            binOut_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            errAcc_q <= errAcc_d;
            binOut_q <= binOut_d;
            err_q    <= err_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign bin_out = binOut_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Testbench for bcd_to_bin_seq. It uses a table of fixed vectors, hand-written handshake sequences,
// and random vectors that are checked against a positional-weight decimal model.
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [4*DIGITS-1:0] bcd_in;
    logic                busy;
    logic                done;
    logic [BIN_W-1:0]    bin_out;
    logic                err;

    int checks = 0;
    int errors = 0;

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bcd_in (bcd_in),
        .busy   (busy),
        .done   (done),
        .bin_out(bin_out),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        int          expBin;
        bit          expErr;
    } vec_t;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Each decimal digit is weighted by its place value. Any nibble above 9 gives zero with err set.
    function automatic void refModel(input logic [15:0] bcd, output int val, output bit e);
        int weight;
        int d;
        val    = 0;
        e      = 1'b0;
        weight = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'((bcd >> (4 * i)) & 16'h000F);
            if (d > 9) e = 1'b1;
            val += d * weight;
            weight *= 10;
        end
        if (e) val = 0;
    endfunction

    // Pulse start for one cycle and wait for done. Then check the latency, busy, the result and the done width.
    task automatic applyStimulus(input string tag, input logic [15:0] bcd,
                                 input int expBin, input bit expErr);
        int  cycles;
        bit  busyOk;
        @(negedge clk);
        bcd_in = bcd;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = ~bcd;
        cycles = 1;
        busyOk = (busy == 1'b1);
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (!busy) busyOk = 1'b0;
        end
        checkOutput({tag, " latency"}, cycles, DIGITS + 1);
        checkOutput({tag, " busy"}, int'(busyOk), 1);
        checkOutput({tag, " bin_out"}, int'(bin_out), expBin);
        checkOutput({tag, " err"}, int'(err), int'(expErr));
        @(negedge clk);
        checkOutput({tag, " done width"}, int'(done), 0);
        checkOutput({tag, " busy after"}, int'(busy), 0);
        checkOutput({tag, " bin_out held"}, int'(bin_out), expBin);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        table_v[8];
        int          doneCycles[$];
        int          doneBins[$];
        int          refVal;
        bit          refErr;
        bit          sawDone;
        logic [15:0] rb;

        table_v[0] = '{16'h1234, 1234, 1'b0};
        table_v[1] = '{16'h9999, 9999, 1'b0};
        table_v[2] = '{16'h0000, 0,    1'b0};
        table_v[3] = '{16'h12A4, 0,    1'b1};
        table_v[4] = '{16'h0001, 1,    1'b0};
        table_v[5] = '{16'hF000, 0,    1'b1};
        table_v[6] = '{16'h0009, 9,    1'b0};
        table_v[7] = '{16'h9000, 9000, 1'b0};

        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset bin_out", int'(bin_out), 0);
        checkOutput("reset err", int'(err), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            applyStimulus($sformatf("vec%0d", i), table_v[i].bcd, table_v[i].expBin, table_v[i].expErr);

        // Hold start high across two conversions and disturb bcd_in while each conversion runs.
        @(negedge clk);
        bcd_in = 16'h0042;
        start  = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) bcd_in = 16'h0100;
            if (c == 6) start = 1'b0;
            if (c == 7) bcd_in = 16'h9999;
            if (done) begin
                doneCycles.push_back(c);
                doneBins.push_back(int'(bin_out));
            end
        end
        checkOutput("b2b done count", doneCycles.size(), 2);
        if (doneCycles.size() == 2) begin
            checkOutput("b2b first done cycle", doneCycles[0], 5);
            checkOutput("b2b spacing", doneCycles[1] - doneCycles[0], 5);
            checkOutput("b2b first bin", doneBins[0], 42);
            checkOutput("b2b second bin", doneBins[1], 100);
        end
        checkOutput("b2b idle after", int'(busy), 0);

        // Reset two cycles into a conversion. The conversion is dropped and no done pulse appears.
        @(negedge clk);
        bcd_in = 16'h1234;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy async", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sawDone = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        checkOutput("abort no done", int'(sawDone), 0);
        checkOutput("abort bin_out", int'(bin_out), 0);
        checkOutput("abort err", int'(err), 0);
        applyStimulus("post-abort", 16'h0567, 567, 1'b0);

        // Random vectors. About one in eight has one digit forced into the illegal range.
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < DIGITS; i++)
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0)
                rb[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            refModel(rb, refVal, refErr);
            applyStimulus($sformatf("rand%0d", n), rb, refVal, refErr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
